// File: rtl/mc_ctrl_fsm_if.sv
// Datapath control bundle between the multi-cycle control FSM and the
// MIPS-subset datapath (PC, IR, register file, ALU, data memory).
//
// Data-memory handshake: mem_req is the valid of a request and mem_we
// qualifies it as a write (mem_we means nothing while mem_req is low).
// The request is held stable until the memory answers with mem_ready
// (ready). The transfer completes on the rising edge where both mem_req
// and mem_ready are high. A request that never sees mem_ready is
// withdrawn by the controller after its timeout.
interface mc_ctrl_fsm_if;
    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ready;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [1:0]  alu_op;
    logic        alu_src_b;
    logic        ext_op;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        mem_req;
    logic        mem_we;

    modport master (
        input  instr, alu_zero, mem_ready,
        output ir_we, pc_we, pc_sel, alu_op, alu_src_b, ext_op,
               reg_we, reg_dst, wd_sel, mem_req, mem_we
    );

    modport slave (
        output instr, alu_zero, mem_ready,
        input  ir_we, pc_we, pc_sel, alu_op, alu_src_b, ext_op,
               reg_we, reg_dst, wd_sel, mem_req, mem_we
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the MIPS-subset datapath. Sequences each
// instruction through FETCH, DECODE, EXEC, MEM and WB, drives all datapath
// enables/selects combinationally from state and the internal IR copy, and
// keeps a retired-instruction counter plus sticky illegal/bus-error flags.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    mc_ctrl_fsm_if.master      dp,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   retired,
    output logic               illegal,
    output logic               bus_error
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    // Last MEM cycle index (counter value) before the access is aborted.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q, bus_error_q;
    logic             ret_inc, set_ill, set_bus;

    // Instruction decode from the internal IR copy.
    logic [5:0] opcode, funct;
    logic is_nop, is_rtype, is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_legal;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign is_nop   = (ir_q == 32'd0);
    assign is_rtype = (opcode == OP_RTYPE) && !is_nop;
    assign is_addu  = is_rtype && (funct == FN_ADDU);
    assign is_subu  = is_rtype && (funct == FN_SUBU);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_ori   = (opcode == OP_ORI);
    assign is_lui   = (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_jal   = (opcode == OP_JAL);
    assign is_legal = is_nop | is_addu | is_subu | is_jr | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_jal;

    // State, IR copy, timeout counter, retired counter and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            ir_q        <= 32'd0;
            tmo_q       <= 8'd0;
            retired_q   <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            tmo_q       <= tmo_d;
            if (ret_inc) retired_q <= retired_q + CNT_W'(1);
            illegal_q   <= illegal_q | set_ill;
            bus_error_q <= bus_error_q | set_bus;
        end
    end

    // Next-state logic and combinational control outputs.
    always_comb begin
        state_d      = S_FETCH;
        ir_d         = ir_q;
        tmo_d        = 8'd0;
        ret_inc      = 1'b0;
        set_ill      = 1'b0;
        set_bus      = 1'b0;
        dp.ir_we     = 1'b0;
        dp.pc_we     = 1'b0;
        dp.pc_sel    = 2'd0;
        dp.alu_op    = 2'd0;
        dp.alu_src_b = 1'b0;
        dp.ext_op    = 1'b0;
        dp.reg_we    = 1'b0;
        dp.reg_dst   = 2'd0;
        dp.wd_sel    = 2'd0;
        dp.mem_req   = 1'b0;
        dp.mem_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                dp.ir_we = 1'b1;
                dp.pc_we = 1'b1;
                ir_d     = dp.instr;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (!is_legal || is_nop) begin
                    set_ill = !is_legal;
                    ret_inc = 1'b1;
                end else if (is_jal) begin
                    dp.reg_we  = 1'b1;
                    dp.reg_dst = 2'd2;
                    dp.wd_sel  = 2'd2;
                    dp.pc_we   = 1'b1;
                    dp.pc_sel  = 2'd2;
                    ret_inc    = 1'b1;
                end else if (is_jr) begin
                    dp.pc_we  = 1'b1;
                    dp.pc_sel = 2'd3;
                    ret_inc   = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                if (is_subu) begin
                    dp.alu_op = 2'd1;
                end else if (is_ori) begin
                    dp.alu_op    = 2'd2;
                    dp.alu_src_b = 1'b1;
                end else if (is_lui) begin
                    dp.alu_op    = 2'd3;
                    dp.alu_src_b = 1'b1;
                end else if (is_lw || is_sw) begin
                    dp.alu_src_b = 1'b1;
                    dp.ext_op    = 1'b1;
                    state_d      = S_MEM;
                end else if (is_beq) begin
                    dp.alu_op = 2'd1;
                    dp.ext_op = 1'b1;
                    dp.pc_sel = 2'd1;
                    dp.pc_we  = dp.alu_zero;
                    state_d   = S_FETCH;
                    ret_inc   = 1'b1;
                end
            end
            S_MEM: begin
                // Keep the address computation driven for the whole access.
                dp.alu_src_b = 1'b1;
                dp.ext_op    = 1'b1;
                dp.mem_req   = 1'b1;
                dp.mem_we    = is_sw;
                if (dp.mem_ready) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                    ret_inc = is_sw;
                end else if (tmo_q == TMO_LAST) begin
                    set_bus = 1'b1;
                end else begin
                    tmo_d   = tmo_q + 8'd1;
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                dp.reg_we  = 1'b1;
                dp.reg_dst = is_rtype ? 2'd1 : 2'd0;
                dp.wd_sel  = is_lw ? 2'd1 : 2'd0;
                ret_inc    = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (reset) begin
            dp.ir_we     = 1'b0;
            dp.pc_we     = 1'b0;
            dp.pc_sel    = 2'd0;
            dp.alu_op    = 2'd0;
            dp.alu_src_b = 1'b0;
            dp.ext_op    = 1'b0;
            dp.reg_we    = 1'b0;
            dp.reg_dst   = 2'd0;
            dp.wd_sel    = 2'd0;
            dp.mem_req   = 1'b0;
            dp.mem_we    = 1'b0;
        end
    end

    assign state     = state_q;
    assign retired   = retired_q;
    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;
endmodule
